// File: rtl/param_watch.sv
// rtl/param_watch.sv - time-of-day counter with load, 12/24 h display and 4-digit 7-segment scan
module param_watch #(
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       disp_sel,
  input  logic       load,
  input  logic [4:0] load_hrs,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic       tick,
  output logic       load_err,
  output logic [3:0] Anode_Activate,
  output logic [6:0] Cathode_Activate
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [4:0]              hrs_q, hrs_d;
  logic [5:0]              min_q, min_d;
  logic [5:0]              sec_q, sec_d;
  logic                    tick_q, tick_d;
  logic                    load_err_q, load_err_d;
  logic [REFRESH_BITS-1:0] refresh_q;

  logic                    load_ok;
  logic [4:0]              disp_hour;
  logic [5:0]              left_val, right_val;
  logic [3:0]              digit;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b0000001;
    endcase
  endfunction

  // Next time/prescaler: a valid load beats a due second; a rejected load lets the advance proceed.
  always_comb begin
    presc_d    = presc_q;
    hrs_d      = hrs_q;
    min_d      = min_q;
    sec_d      = sec_q;
    tick_d     = 1'b0;
    load_ok    = load && (load_hrs <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
    load_err_d = load && !load_ok;
    if (load_ok) begin
      hrs_d   = load_hrs;
      min_d   = load_min;
      sec_d   = load_sec;
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Timekeeping state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      hrs_q      <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hrs_q      <= hrs_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Free-running scan counter; runs regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Pick the digit pair and the scanned digit, then encode it.
  always_comb begin
    if (!mode_12h)             disp_hour = hrs_q;
    else if (hrs_q == 5'd0)    disp_hour = 5'd12;
    else if (hrs_q > 5'd12)    disp_hour = hrs_q - 5'd12;
    else                       disp_hour = hrs_q;
    left_val  = disp_sel ? {1'b0, disp_hour} : min_q;
    right_val = disp_sel ? min_q : sec_q;
    case (refresh_q[REFRESH_BITS-1 -: 2])
      2'b00: begin Anode_Activate = 4'b0111; digit = 4'(left_val / 6'd10);  end
      2'b01: begin Anode_Activate = 4'b1011; digit = 4'(left_val % 6'd10);  end
      2'b10: begin Anode_Activate = 4'b1101; digit = 4'(right_val / 6'd10); end
      default: begin Anode_Activate = 4'b1110; digit = 4'(right_val % 6'd10); end
    endcase
    Cathode_Activate = seg_code(digit);
  end

  assign hrs      = hrs_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign pm       = (hrs_q >= 5'd12);
  assign tick     = tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_param_watch.sv
// tb/tb_param_watch.sv - scoreboard bench for param_watch against a seconds-of-day model
module tb_param_watch;
  localparam int CLK_HZ = 4;
  localparam int RB     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, mode_12h, disp_sel, load;
  logic [4:0] load_hrs;
  logic [5:0] load_min, load_sec;
  logic [4:0] hrs;
  logic [5:0] min, sec;
  logic       pm, tick, load_err;
  logic [3:0] Anode_Activate;
  logic [6:0] Cathode_Activate;

  param_watch #(.CLK_HZ(CLK_HZ), .REFRESH_BITS(RB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_12h(mode_12h), .disp_sel(disp_sel),
    .load(load), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
    .hrs(hrs), .min(min), .sec(sec), .pm(pm), .tick(tick), .load_err(load_err),
    .Anode_Activate(Anode_Activate), .Cathode_Activate(Cathode_Activate)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tsec;
    int refr;
    bit tick;
    bit lerr;
    bit m12;
    bit ds;
  } exp_t;

  exp_t q[$];
  int   m_tsec, m_presc, m_refr;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_anode(input int refr);
    int sel = (refr >> (RB - 2)) & 3;
    return 15 ^ (8 >> sel);
  endfunction

  function automatic int exp_cath(input int tsec, input int refr, input bit m12, input bit ds);
    int h, mi, s, dh, left, right, sel, val;
    h  = tsec / 3600;
    mi = (tsec / 60) % 60;
    s  = tsec % 60;
    dh = m12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    left  = ds ? dh : mi;
    right = ds ? mi : s;
    sel   = (refr >> (RB - 2)) & 3;
    case (sel)
      0:       val = left / 10;
      1:       val = left % 10;
      2:       val = right / 10;
      default: val = right % 10;
    endcase
    return int'(seg_tab[val]);
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, queue the expectation.
  task automatic drive_cycle(input bit en, input bit m12, input bit ds, input bit ld,
                             input int lh, input int lm, input int ls);
    exp_t e;
    bit   lv;
    enable   = en;
    mode_12h = m12;
    disp_sel = ds;
    load     = ld;
    load_hrs = 5'(lh);
    load_min = 6'(lm);
    load_sec = 6'(ls);
    lv     = ld && lh <= 23 && lm <= 59 && ls <= 59;
    e.lerr = ld && !lv;
    e.tick = 1'b0;
    if (lv) begin
      m_tsec  = lh * 3600 + lm * 60 + ls;
      m_presc = 0;
    end else if (en) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        m_tsec  = (m_tsec + 1) % 86400;
        e.tick  = 1'b1;
      end else begin
        m_presc++;
      end
    end
    m_refr = (m_refr + 1) % (1 << RB);
    e.tsec = m_tsec;
    e.refr = m_refr;
    e.m12  = m12;
    e.ds   = ds;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: every negedge with a pending expectation, compare the whole output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hrs", int'(hrs), e.tsec / 3600);
        check("min", int'(min), (e.tsec / 60) % 60);
        check("sec", int'(sec), e.tsec % 60);
        check("pm", int'(pm), int'(e.tsec >= 12 * 3600));
        check("tick", int'(tick), int'(e.tick));
        check("load_err", int'(load_err), int'(e.lerr));
        check("anode", int'(Anode_Activate), exp_anode(e.refr));
        check("cathode", int'(Cathode_Activate), exp_cath(e.tsec, e.refr, e.m12, e.ds));
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_hrs"}, int'(hrs), 0);
    check({tag, "_min"}, int'(min), 0);
    check({tag, "_sec"}, int'(sec), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_lerr"}, int'(load_err), 0);
    check({tag, "_pm"}, int'(pm), 0);
    check({tag, "_anode"}, int'(Anode_Activate), 4'b0111);
  endtask

  initial begin
    int guard;
    reset = 1'b0; enable = 1'b1; mode_12h = 1'b0; disp_sel = 1'b0;
    load = 1'b0; load_hrs = '0; load_min = '0; load_sec = '0;
    m_tsec = 0; m_presc = 0; m_refr = 0;
    #2;
    reset_checks("rst");
    check("rst_cath_mmss", int'(Cathode_Activate), 7'b0000001);
    disp_sel = 1'b1; mode_12h = 1'b1; #1;
    check("rst_cath_12h", int'(Cathode_Activate), 7'b1001111);
    mode_12h = 1'b0; #1;
    check("rst_cath_24h", int'(Cathode_Activate), 7'b0000001);
    @(negedge clk); #1;
    reset = 1'b1;

    // Midnight rollover from 23:59:59.
    drive_cycle(1, 0, 0, 1, 23, 59, 59);
    for (int i = 0; i < 5; i++) drive_cycle(1, 0, 1, 0, 0, 0, 0);
    // 13:05:00 in 12 h and 24 h HH:MM, full scans; then frozen while disabled.
    drive_cycle(1, 1, 1, 1, 13, 5, 0);
    for (int i = 0; i < 16; i++) drive_cycle(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive_cycle(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 1, 1, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 7, 8, 9);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0);
    // Rejected loads.
    drive_cycle(1, 0, 0, 1, 10, 60, 0);
    drive_cycle(1, 0, 0, 1, 24, 0, 0);
    drive_cycle(1, 0, 0, 1, 3, 3, 63);
    // Valid load exactly when a second is due.
    guard = 0;
    while (m_presc != CLK_HZ - 1 && guard < 10) begin
      drive_cycle(1, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    check("presc_reach_max", m_presc, CLK_HZ - 1);
    drive_cycle(1, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit ld = ($urandom % 6) == 0;
      int lh = (($urandom % 5) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      int lm = (($urandom % 5) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      int ls = (($urandom % 5) == 0) ? $urandom_range(60, 63) : (($urandom % 2) ? 59 : $urandom_range(0, 59));
      drive_cycle(($urandom % 6) != 0, $urandom % 2, $urandom % 2, ld, lh, lm, ls);
    end

    // Asynchronous reset mid-count at 12:34:56.
    drive_cycle(1, 0, 0, 1, 12, 34, 56);
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    check("pre_rst_queue", q.size(), 0);
    @(posedge clk); #3;
    disp_sel = 1'b1; mode_12h = 1'b1;
    reset = 1'b0;
    #1;
    reset_checks("async");
    check("async_cath", int'(Cathode_Activate), 7'b1001111);
    repeat (2) @(negedge clk);
    check("async_hold_anode", int'(Anode_Activate), 4'b0111);
    #1;
    reset = 1'b1;
    m_tsec = 0; m_presc = 0; m_refr = 0;
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, 1, 0, 0, 0, 0);

    guard = 0;
    while (q.size() > 0 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("queue_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
